// File: rtl/cpu_alu_arb.sv
// cpu_alu_arb: round-robin arbiter that shares one multicycle ALU
// between two requesters (A and B), with per-requester response channels.
//
// Optional feature macro: CPU_ALU_ARB_DIVZERO_EN
//   defined   -> DIV/MOD by zero skip EXEC, answer 32'hFFFFFFFF, err=1
//   undefined -> DIV/MOD by zero run normally and return alu_value
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   a_/b_valid, a_/b_ready      request handshake per requester
//   a_/b_arg1, a_/b_arg2        32-bit operands per requester
//   a_/b_opcode                 16-bit opcode per requester
//   a_/b_resp_valid/_ready      response handshake per requester
//   resp_value, resp_err        shared response payload
//   alu_arg1/arg2/opcode        registered drive into the shared ALU
//   alu_value                   combinational ALU result
//   busy                        high whenever not IDLE
module cpu_alu_arb #(
  parameter int LONG_CYCLES  = 4,
  parameter int SHORT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_arg1,
  input  logic [31:0] a_arg2,
  input  logic [15:0] a_opcode,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_arg1,
  input  logic [31:0] b_arg2,
  input  logic [15:0] b_opcode,
  output logic        a_resp_valid,
  input  logic        a_resp_ready,
  output logic        b_resp_valid,
  input  logic        b_resp_ready,
  output logic [31:0] resp_value,
  output logic        resp_err,
  output logic [31:0] alu_arg1,
  output logic [31:0] alu_arg2,
  output logic [15:0] alu_opcode,
  input  logic [31:0] alu_value,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_RESP = 2'b10
  } state_t;

  localparam logic [3:0] LC = 4'(LONG_CYCLES);
  localparam logic [3:0] SC = 4'(SHORT_CYCLES);

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_last;
  logic        r_illegal;
  logic [31:0] r_arg1;
  logic [31:0] r_arg2;
  logic [15:0] r_op;
  logic [31:0] r_resp_value;
  logic        r_resp_err;

  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_accept;
  logic [31:0] w_in_arg1;
  logic [31:0] w_in_arg2;
  logic [15:0] w_in_op;
  logic        w_in_long;
  logic        w_in_illegal;
  logic        w_in_divzero;
  logic        w_done;
  logic        w_hs;

  // r_owner / r_last: 0 = A, 1 = B
  assign w_accept  = w_grant_a | w_grant_b;
  assign w_in_arg1 = w_grant_b ? b_arg1 : a_arg1;
  assign w_in_arg2 = w_grant_b ? b_arg2 : a_arg2;
  assign w_in_op   = w_grant_b ? b_opcode : a_opcode;

  assign w_in_long = (w_in_op == 16'h0002)
                   | (w_in_op == 16'h0003)
                   | (w_in_op == 16'h0004);

  assign w_in_illegal = !((w_in_op <= 16'h0009)
                        | (w_in_op == 16'h0010));

`ifdef CPU_ALU_ARB_DIVZERO_EN
  assign w_in_divzero = ((w_in_op == 16'h0003)
                       | (w_in_op == 16'h0004))
                      & (w_in_arg2 == 32'd0);
`else
  assign w_in_divzero = 1'b0;
`endif

  // A zero count can only come from an out-of-range parameter;
  // finish rather than wrap so the FSM can never stall in EXEC.
  assign w_done = (r_state == S_EXEC) && (r_cnt <= 4'd1);

  assign w_hs = (r_state == S_RESP)
              && (r_owner ? b_resp_ready : a_resp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Tie goes to whoever was not served last.
        if (a_valid && (!b_valid || r_last)) begin
          w_grant_a = 1'b1;
        end else if (b_valid) begin
          w_grant_b = 1'b1;
        end
        if (w_grant_a || w_grant_b) begin
          w_next = w_in_divzero ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_done) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (w_hs) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 4'd0;
      r_owner      <= 1'b0;
      r_last       <= 1'b1;
      r_illegal    <= 1'b0;
      r_arg1       <= 32'd0;
      r_arg2       <= 32'd0;
      r_op         <= 16'd0;
      r_resp_value <= 32'd0;
      r_resp_err   <= 1'b0;
    end else if (w_accept) begin
      r_arg1    <= w_in_arg1;
      r_arg2    <= w_in_arg2;
      r_op      <= w_in_op;
      r_owner   <= w_grant_b;
      r_last    <= w_grant_b;
      r_illegal <= w_in_illegal;
      if (w_in_divzero) begin
        r_cnt        <= 4'd0;
        r_resp_value <= 32'hFFFF_FFFF;
        r_resp_err   <= 1'b1;
      end else begin
        r_cnt <= w_in_long ? LC : SC;
      end
    end else if (r_state == S_EXEC) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_done) begin
        r_resp_value <= r_illegal ? 32'd0 : alu_value;
        r_resp_err   <= r_illegal;
      end
    end
  end

  assign a_ready      = w_grant_a;
  assign b_ready      = w_grant_b;
  assign a_resp_valid = (r_state == S_RESP) && !r_owner;
  assign b_resp_valid = (r_state == S_RESP) && r_owner;
  assign resp_value   = r_resp_value;
  assign resp_err     = r_resp_err;
  assign alu_arg1     = r_arg1;
  assign alu_arg2     = r_arg2;
  assign alu_opcode   = r_op;
  assign busy         = (r_state != S_IDLE);

  a_one_ready: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(a_ready && b_ready));

  a_one_resp: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(a_resp_valid && b_resp_valid));

  a_alu_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (r_state == S_EXEC && !w_done) |=>
      ($stable(alu_opcode) && $stable(alu_arg1)
       && $stable(alu_arg2)));

endmodule

// File: tb/tb_cpu_alu_arb.sv
// tb_cpu_alu_arb: scoreboard bench for cpu_alu_arb with a
// behavioural ALU model; default LONG_CYCLES=4, SHORT_CYCLES=1.
module tb_cpu_alu_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [31:0] a_arg1 = '0, a_arg2 = '0;
  logic [31:0] b_arg1 = '0, b_arg2 = '0;
  logic [15:0] a_opcode = '0, b_opcode = '0;
  logic        a_resp_valid, b_resp_valid;
  logic        a_resp_ready = 1'b0, b_resp_ready = 1'b0;
  logic [31:0] resp_value;
  logic        resp_err;
  logic [31:0] alu_arg1, alu_arg2;
  logic [15:0] alu_opcode;
  logic [31:0] alu_value;
  logic        busy;

  typedef struct {
    bit          own;
    logic [31:0] val;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cpu_alu_arb dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready),
    .a_arg1(a_arg1), .a_arg2(a_arg2),
    .a_opcode(a_opcode),
    .b_valid(b_valid), .b_ready(b_ready),
    .b_arg1(b_arg1), .b_arg2(b_arg2),
    .b_opcode(b_opcode),
    .a_resp_valid(a_resp_valid),
    .a_resp_ready(a_resp_ready),
    .b_resp_valid(b_resp_valid),
    .b_resp_ready(b_resp_ready),
    .resp_value(resp_value), .resp_err(resp_err),
    .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .alu_opcode(alu_opcode),
    .alu_value(alu_value), .busy(busy)
  );

  // Shared ALU model; divide by zero yields a marker value.
  always_comb begin
    case (alu_opcode)
      16'h0: alu_value = alu_arg1 + alu_arg2;
      16'h1: alu_value = alu_arg1 - alu_arg2;
      16'h2: alu_value = alu_arg1 * alu_arg2;
      16'h3: alu_value = (alu_arg2 == 0) ? 32'hDEADBEEF
                         : alu_arg1 / alu_arg2;
      16'h4: alu_value = (alu_arg2 == 0) ? 32'hDEADBEEF
                         : alu_arg1 % alu_arg2;
      16'h5: alu_value = alu_arg1 & alu_arg2;
      16'h6: alu_value = alu_arg1 | alu_arg2;
      16'h7: alu_value = alu_arg1 ^ alu_arg2;
      16'h8: alu_value = alu_arg1 << alu_arg2[4:0];
      16'h9: alu_value = alu_arg1 >> alu_arg2[4:0];
      16'h10: alu_value = alu_arg1 >> alu_arg2[4:0];
      default: alu_value = 32'h5A5A5A5A;
    endcase
  end

  task automatic do_reset();
    a_valid = 0; b_valid = 0;
    a_resp_ready = 0; b_resp_ready = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  // Presents one request for a cycle; leaves in cycle 1.
  task automatic issue(input bit own, input logic [15:0] op,
                       input logic [31:0] x, input logic [31:0] y,
                       output bit rdy);
    if (own) begin
      b_valid = 1; b_opcode = op; b_arg1 = x; b_arg2 = y;
    end else begin
      a_valid = 1; a_opcode = op; a_arg1 = x; a_arg2 = y;
    end
    #1;
    rdy = own ? b_ready : a_ready;
    @(posedge clk); #1;
    a_valid = 0; b_valid = 0;
  endtask

  // Returns the cycle index (first call = cycle k0) of resp_valid, or -1.
  task automatic wait_resp(input bit own, input int k0,
                           input int maxc, output int cyc);
    cyc = -1;
    for (int k = k0; k < k0 + maxc; k++) begin
      if (own ? b_resp_valid : a_resp_valid) begin
        cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic consume(input bit own);
    if (own) b_resp_ready = 1; else a_resp_ready = 1;
    @(posedge clk); #1;
    a_resp_ready = 0; b_resp_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL rst_busy got=%0h exp=0", busy); end
    n_cmp++; if ({a_resp_valid, b_resp_valid} !== 2'b00) begin
      n_err++; $display("FAIL rst_rv got=%b exp=00",
        {a_resp_valid, b_resp_valid}); end
    n_cmp++; if (resp_value !== 32'd0) begin n_err++;
      $display("FAIL rst_val got=%h exp=0", resp_value); end
    n_cmp++; if (resp_err !== 1'b0) begin n_err++;
      $display("FAIL rst_err got=%h exp=0", resp_err); end
    n_cmp++; if ({alu_opcode, alu_arg1, alu_arg2} !== 80'd0)
      begin n_err++; $display("FAIL rst_alu got=%h/%h/%h exp=0",
        alu_opcode, alu_arg1, alu_arg2); end
    rst_n = 1;
  endtask

  task automatic test_add_a();
    bit r; int c; exp_t e;
    issue(0, 16'h0, 32'd5, 32'd7, r);
    n_cmp++; if (r !== 1'b1) begin n_err++;
      $display("FAIL add_ready got=%0d exp=1", r); end
    sb.push_back('{0, 32'd12, 1'b0, 2});
    wait_resp(0, 1, 6, c);
    e = sb.pop_front();
    n_cmp++; if (c !== e.lat) begin n_err++;
      $display("FAIL add_lat got=%0d exp=%0d", c, e.lat); end
    n_cmp++; if (resp_value !== e.val) begin n_err++;
      $display("FAIL add_val got=%0d exp=%0d", resp_value, e.val); end
    n_cmp++; if (resp_err !== e.err) begin n_err++;
      $display("FAIL add_err got=%0d exp=%0d", resp_err, e.err); end
    n_cmp++; if (b_resp_valid !== 1'b0) begin n_err++;
      $display("FAIL add_brv got=%0d exp=0", b_resp_valid); end
    consume(0);
    n_cmp++; if (busy !== 1'b0 || a_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL add_done got=%0d%0d exp=00",
        busy, a_resp_valid); end
  endtask

  task automatic test_illegal_b();
    bit r; int c; exp_t e;
    issue(1, 16'h000A, 32'd3, 32'd4, r);
    sb.push_back('{1, 32'd0, 1'b1, 2});
    wait_resp(1, 1, 6, c);
    e = sb.pop_front();
    n_cmp++; if (c !== e.lat || a_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL ill_lat got=%0d/%0d exp=%0d/0",
        c, a_resp_valid, e.lat); end
    n_cmp++; if (resp_value !== e.val || resp_err !== e.err) begin
      n_err++; $display("FAIL ill_val got=%h/%0d exp=%h/%0d",
        resp_value, resp_err, e.val, e.err); end
    consume(1);
    issue(1, 16'h0010, 32'h80, 32'd4, r);
    sb.push_back('{1, 32'h8, 1'b0, 2});
    wait_resp(1, 1, 6, c);
    e = sb.pop_front();
    n_cmp++; if (c !== e.lat) begin n_err++;
      $display("FAIL op10_lat got=%0d exp=%0d", c, e.lat); end
    n_cmp++; if (resp_value !== e.val || resp_err !== e.err) begin
      n_err++; $display("FAIL op10_val got=%h/%0d exp=%h/%0d",
        resp_value, resp_err, e.val, e.err); end
    consume(1);
  endtask

  task automatic test_mul_hold();
    bit r; int c; exp_t e;
    issue(0, 16'h2, 32'd6, 32'd7, r);
    sb.push_back('{0, 32'd42, 1'b0, 5});
    for (int k = 1; k <= 4; k++) begin
      a_arg1 = 32'd99; a_arg2 = 32'd1; a_opcode = 16'h0;
      n_cmp++; if (alu_opcode !== 16'h2 || alu_arg1 !== 32'd6
                   || alu_arg2 !== 32'd7 || a_resp_valid !== 1'b0)
      begin n_err++; $display("FAIL mul_alu c%0d got=%h/%0d/%0d/%0d",
        k, alu_opcode, alu_arg1, alu_arg2, a_resp_valid); end
      @(posedge clk); #1;
    end
    wait_resp(0, 5, 1, c);
    e = sb.pop_front();
    n_cmp++; if (c !== e.lat) begin n_err++;
      $display("FAIL mul_lat got=%0d exp=%0d", c, e.lat); end
    a_valid = 1; b_resp_ready = 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (a_resp_valid !== 1'b1 || resp_value !== e.val
                   || resp_err !== e.err || a_ready !== 1'b0) begin
        n_err++; $display("FAIL mul_hold c%0d got=%0d/%0d/%0d/%0d",
          k, a_resp_valid, resp_value, resp_err, a_ready); end
      @(posedge clk); #1;
    end
    a_valid = 0; b_resp_ready = 0;
    consume(0);
    n_cmp++; if (busy !== 1'b0) begin n_err++;
      $display("FAIL mul_done got=%0d exp=0", busy); end
  endtask

  task automatic test_divzero();
    bit r; int c; exp_t e;
    issue(0, 16'h3, 32'd9, 32'd0, r);
`ifdef CPU_ALU_ARB_DIVZERO_EN
    sb.push_back('{0, 32'hFFFFFFFF, 1'b1, 1});
`else
    sb.push_back('{0, 32'hDEADBEEF, 1'b0, 5});
`endif
    wait_resp(0, 1, 8, c);
    e = sb.pop_front();
    n_cmp++; if (c !== e.lat) begin n_err++;
      $display("FAIL dz_lat got=%0d exp=%0d", c, e.lat); end
    n_cmp++; if (resp_value !== e.val || resp_err !== e.err) begin
      n_err++; $display("FAIL dz_val got=%h/%0d exp=%h/%0d",
        resp_value, resp_err, e.val, e.err); end
    consume(0);
    issue(1, 16'h4, 32'd9, 32'd4, r);
    sb.push_back('{1, 32'd1, 1'b0, 5});
    wait_resp(1, 1, 8, c);
    e = sb.pop_front();
    n_cmp++; if (c !== e.lat || resp_value !== e.val
                 || resp_err !== e.err) begin
      n_err++; $display("FAIL mod_res got=%0d/%0d/%0d exp=%0d/%0d/%0d",
        c, resp_value, resp_err, e.lat, e.val, e.err); end
    consume(1);
  endtask

  task automatic test_tie();
    int c; exp_t e;
    do_reset();
    a_valid = 1; a_opcode = 16'h1; a_arg1 = 32'd10; a_arg2 = 32'd3;
    b_valid = 1; b_opcode = 16'h1; b_arg1 = 32'd10; b_arg2 = 32'd3;
    #1;
    n_cmp++; if ({a_ready, b_ready} !== 2'b10) begin n_err++;
      $display("FAIL tie_grant got=%b exp=10", {a_ready, b_ready});
    end
    sb.push_back('{0, 32'd7, 1'b0, 2});
    @(posedge clk); #1;
    a_valid = 0;
    #1;
    n_cmp++; if (b_ready !== 1'b0) begin n_err++;
      $display("FAIL tie_busy_rdy got=%0d exp=0", b_ready); end
    wait_resp(0, 1, 6, c);
    e = sb.pop_front();
    n_cmp++; if (c !== e.lat || resp_value !== e.val) begin
      n_err++; $display("FAIL tie_a got=%0d/%0d exp=%0d/%0d",
        c, resp_value, e.lat, e.val); end
    consume(0);
    #1;
    n_cmp++; if (b_ready !== 1'b1) begin n_err++;
      $display("FAIL tie_b_next got=%0d exp=1", b_ready); end
    sb.push_back('{1, 32'd7, 1'b0, 2});
    @(posedge clk); #1;
    b_valid = 0;
    wait_resp(1, 1, 6, c);
    e = sb.pop_front();
    n_cmp++; if (c !== e.lat || resp_value !== e.val
                 || resp_err !== e.err) begin
      n_err++; $display("FAIL tie_b got=%0d/%0d exp=%0d/%0d",
        c, resp_value, e.lat, e.val); end
    consume(1);
  endtask

  task automatic test_back_to_back();
    int  n_acc = 0, n_resp = 0, last_acc = -1;
    bit  exp_own = 0;
    bit  g;
    exp_t e;
    do_reset();
    a_valid = 1; a_opcode = 16'h0; a_arg1 = 32'd1; a_arg2 = 32'd2;
    b_valid = 1; b_opcode = 16'h1; b_arg1 = 32'd9; b_arg2 = 32'd4;
    #1;
    for (int cyc = 0; cyc < 60 && n_resp < 4; cyc++) begin
      if (a_ready || b_ready) begin
        g = b_ready;
        n_cmp++; if (g !== exp_own) begin n_err++;
          $display("FAIL b2b_owner c%0d got=%0d exp=%0d",
            cyc, g, exp_own); end
        if (last_acc >= 0) begin
          n_cmp++; if (cyc - last_acc !== 3) begin n_err++;
            $display("FAIL b2b_gap got=%0d exp=3", cyc - last_acc);
          end
        end
        if (g) sb.push_back('{1, 32'd5, 1'b0, 0});
        else   sb.push_back('{0, 32'd3, 1'b0, 0});
        exp_own = ~exp_own;
        last_acc = cyc;
        n_acc++;
      end
      if (a_resp_valid || b_resp_valid) begin
        e = sb.pop_front();
        n_cmp++; if (b_resp_valid !== e.own || resp_value !== e.val
                     || resp_err !== e.err) begin
          n_err++; $display("FAIL b2b_resp got=%0d/%0d/%0d exp=%0d/%0d/%0d",
            b_resp_valid, resp_value, resp_err, e.own, e.val, e.err);
        end
        a_resp_ready = a_resp_valid;
        b_resp_ready = b_resp_valid;
        n_resp++;
      end
      @(posedge clk); #1;
      a_resp_ready = 0; b_resp_ready = 0;
      if (n_acc >= 4) begin a_valid = 0; b_valid = 0; end
      #1;
    end
    a_valid = 0; b_valid = 0;
    n_cmp++; if (n_resp !== 4) begin n_err++;
      $display("FAIL b2b_count got=%0d exp=4", n_resp); end
  endtask

  task automatic test_reset_mid_exec();
    bit r;
    issue(0, 16'h2, 32'd6, 32'd7, r);
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++;
      $display("FAIL mid_busy got=%0d exp=1", busy); end
    rst_n = 0;
    #1;
    n_cmp++; if (busy !== 1'b0 || alu_opcode !== 16'd0
                 || alu_arg1 !== 32'd0 || alu_arg2 !== 32'd0) begin
      n_err++; $display("FAIL mid_rst_alu got=%0d/%h/%h/%h exp=0",
        busy, alu_opcode, alu_arg1, alu_arg2); end
    n_cmp++; if (resp_value !== 32'd0 || resp_err !== 1'b0
                 || a_resp_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_resp got=%h/%0d/%0d exp=0",
        resp_value, resp_err, a_resp_valid); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (a_resp_valid || b_resp_valid || busy) begin
        n_err++; $display("FAIL mid_after c%0d got=%0d%0d%0d exp=000",
          k, a_resp_valid, b_resp_valid, busy); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_add_a();
    test_illegal_b();
    test_mul_hold();
    test_divzero();
    test_tie();
    test_back_to_back();
    test_reset_mid_exec();
    n_cmp++; if (sb.size() !== 0) begin n_err++;
      $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
